// File: rtl/rp_pio_cpl_tracker.sv
// Root Port PIO completion tracker: tag allocation, per-tag timeout and completion
// matching, producing RP PIO Status set pulses. Optional first-error log: RP_PIO_ERR_LOG_EN.

module rp_pio_cpl_tracker_slot #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alloc,
    input  logic [1:0] alloc_space,
    input  logic       cpl_hit,
    input  logic [2:0] cpl_status,
    output logic       busy,
    output logic [1:0] space,
    output logic       ev_ur,
    output logic       ev_ca,
    output logic       ev_cto,
    output logic       ev_unexp
);
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer;
    logic             tmo;

    assign tmo = (state == BUSY) && (timer == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FREE;
            timer <= '0;
            space <= 2'd0;
        end else begin
            state <= state_nxt;
            // Timer only runs while the entry stays outstanding; it restarts from 0 on allocation.
            if (state == BUSY && state_nxt == BUSY)
                timer <= timer + 1'b1;
            else
                timer <= '0;
            if (state == FREE && alloc)
                space <= alloc_space;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FREE:    if (alloc) state_nxt = BUSY;
            BUSY:    if (cpl_hit || tmo) state_nxt = FREE;
            default: state_nxt = FREE;
        endcase
    end

    always_comb begin
        busy     = (state == BUSY);
        ev_ur    = 1'b0;
        ev_ca    = 1'b0;
        if (busy && cpl_hit) begin
            ev_ca = (cpl_status == 3'b100);
            ev_ur = (cpl_status != 3'b000) && (cpl_status != 3'b100);
        end
        // A completion landing on the final timer cycle beats the timeout.
        ev_cto   = tmo && !cpl_hit;
        ev_unexp = !busy && cpl_hit;
    end
endmodule

module rp_pio_cpl_tracker #(
    parameter int NUM_TAGS       = 8,
    parameter int TAG_W          = $clog2(NUM_TAGS),
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_type,
    output logic             req_ready,
    output logic [TAG_W-1:0] req_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    input  logic [2:0]       cpl_status,
    output logic [31:0]      err_set,
    output logic             unexpected_cpl,
    output logic [TAG_W:0]   outstanding_cnt,
    output logic             log_valid,
    output logic [1:0]       log_type,
    output logic [TAG_W-1:0] log_tag,
    input  logic             log_clr
);
    logic [NUM_TAGS-1:0]      busy, gnt, alloc, cpl_hit;
    logic [NUM_TAGS-1:0]      ev_ur, ev_ca, ev_cto, ev_unexp;
    logic [NUM_TAGS-1:0][1:0] space;
    logic [1:0]               alloc_space;
    logic                     run;
    logic [31:0]              err_nxt;
    logic                     unexp_nxt;

    // Reserved request type is tracked as MEM.
    assign alloc_space = (req_type == 2'd3) ? 2'd2 : req_type;
    assign req_ready   = run && !(&busy);

    always_comb begin
        gnt     = '0;
        req_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                req_tag = TAG_W'(i);
            end
        end
    end

    assign alloc = gnt & {NUM_TAGS{req_valid && req_ready}};

    generate
        for (genvar g = 0; g < NUM_TAGS; g++) begin : g_slot
            assign cpl_hit[g] = cpl_valid && (cpl_tag == TAG_W'(g));
            rp_pio_cpl_tracker_slot #(
                .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
                .CNT_W         (CNT_W)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .alloc      (alloc[g]),
                .alloc_space(alloc_space),
                .cpl_hit    (cpl_hit[g]),
                .cpl_status (cpl_status),
                .busy       (busy[g]),
                .space      (space[g]),
                .ev_ur      (ev_ur[g]),
                .ev_ca      (ev_ca[g]),
                .ev_cto     (ev_cto[g]),
                .ev_unexp   (ev_unexp[g])
            );
        end
    endgenerate

    // Each space owns a byte of the status vector: bit 0 UR, bit 1 CA, bit 2 CTO.
    always_comb begin
        logic [4:0] base;
        base      = '0;
        err_nxt   = '0;
        unexp_nxt = |ev_unexp;
        for (int i = 0; i < NUM_TAGS; i++) begin
            base                = {space[i], 3'b000};
            err_nxt[base]       = err_nxt[base]       | ev_ur[i];
            err_nxt[base+5'd1]  = err_nxt[base+5'd1]  | ev_ca[i];
            err_nxt[base+5'd2]  = err_nxt[base+5'd2]  | ev_cto[i];
        end
    end

    always_comb begin
        outstanding_cnt = '0;
        for (int i = 0; i < NUM_TAGS; i++)
            outstanding_cnt = outstanding_cnt + (TAG_W+1)'(busy[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run            <= 1'b0;
            err_set        <= '0;
            unexpected_cpl <= 1'b0;
        end else begin
            run            <= 1'b1;
            err_set        <= err_nxt;
            unexpected_cpl <= unexp_nxt;
        end
    end

`ifdef RP_PIO_ERR_LOG_EN
    logic             err_any;
    logic [1:0]       first_space;
    logic [TAG_W-1:0] first_tag;

    assign err_any = |(ev_ur | ev_ca | ev_cto);

    // Simultaneous errors: the lowest tag is the one logged.
    always_comb begin
        first_space = 2'd0;
        first_tag   = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (ev_ur[i] || ev_ca[i] || ev_cto[i]) begin
                first_space = space[i];
                first_tag   = TAG_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            log_valid <= 1'b0;
            log_type  <= 2'd0;
            log_tag   <= '0;
        end else if (err_any && (!log_valid || log_clr)) begin
            log_valid <= 1'b1;
            log_type  <= first_space;
            log_tag   <= first_tag;
        end else if (log_clr) begin
            log_valid <= 1'b0;
        end
    end
`else
    logic log_clr_unused;
    assign log_clr_unused = log_clr;
    assign log_valid      = 1'b0;
    assign log_type       = 2'd0;
    assign log_tag        = '0;
`endif
endmodule
